// File: rtl/fb_line_fetcher_if.sv
// SDRAM read port and OCM port B, bundled for the line fetcher.
// master = fetcher side, slave = memory/controller side.
interface fb_line_fetcher_if;
  logic [24:0] dram_address;
  logic        dram_read_n;
  logic        dram_waitrequest;
  logic        dram_read_valid;
  logic [15:0] data_from_dram;
  logic [15:0] ocm_addr_b;
  logic [15:0] ocm_datain_b;
  logic        ocm_we_b;

  modport master (
    output dram_address, dram_read_n, ocm_addr_b, ocm_datain_b, ocm_we_b,
    input  dram_waitrequest, dram_read_valid, data_from_dram
  );

  modport slave (
    input  dram_address, dram_read_n, ocm_addr_b, ocm_datain_b, ocm_we_b,
    output dram_waitrequest, dram_read_valid, data_from_dram
  );
endinterface

// File: rtl/fb_line_fetcher.sv
// Fetches one scanline of 16-bit pixels from SDRAM into one half of the
// OCM ping-pong line buffer, keeping up to MAX_OUTSTANDING reads in flight.
module fb_line_fetcher #(
  parameter int          LINE_WORDS      = 640,
  parameter logic [24:0] FB_BASE         = 25'h0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              line_req_i,
  input  logic [9:0]        line_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              overrun_o,
  fb_line_fetcher_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [9:0]  LAST_IDX = 10'(LINE_WORDS - 1);
  localparam logic [9:0]  LINE_CNT = 10'(LINE_WORDS);
  localparam logic [3:0]  MAX_OUT  = 4'(MAX_OUTSTANDING);
  localparam logic [15:0] BANK_OFS = 16'(LINE_WORDS);

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } ocm_wr_t;

  logic [1:0]  state_q, state_d;
  logic [24:0] base_q, base_d;
  logic        bank_q, bank_d;
  logic [9:0]  issue_q, issue_d;
  logic [9:0]  recv_q, recv_d;
  logic [3:0]  outst_q, outst_d;
  logic        rd_n_q, rd_n_d;
  logic [24:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  ocm_wr_t     wr_q, wr_d;

  logic        accept;
  logic        rd_valid;
  logic [24:0] line_base;
  logic [15:0] ocm_row;

  assign line_base = FB_BASE + 25'(line_y_i) * 25'(LINE_WORDS);
  assign accept    = (state_q == S_ISSUE) && !rd_n_q && !bus.dram_waitrequest;
  // Returns with nothing in flight are leftovers from an aborted fetch.
  assign rd_valid  = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                     bus.dram_read_valid && (outst_q != 4'd0);
  assign ocm_row   = bank_q ? BANK_OFS : 16'd0;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    bank_d  = bank_q;
    issue_d = issue_q + 10'(accept);
    recv_d  = recv_q + 10'(rd_valid);
    outst_d = outst_q + {3'b000, accept} - {3'b000, rd_valid};
    rd_n_d  = rd_n_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q | (line_req_i && (state_q != S_IDLE));
    wr_d    = '{we: rd_valid, addr: wr_q.addr, data: wr_q.data};

    if (rd_valid) begin
      wr_d.addr = ocm_row + 16'(recv_q);
      wr_d.data = bus.data_from_dram;
    end

    case (state_q)
      S_IDLE: begin
        if (line_req_i) begin
          state_d = S_ISSUE;
          base_d  = line_base;
          bank_d  = line_y_i[0];
          issue_d = '0;
          recv_d  = '0;
          outst_d = '0;
          rd_n_d  = 1'b0;
          addr_d  = line_base;
          busy_d  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (accept && (issue_q == LAST_IDX)) begin
          state_d = S_DRAIN;
          rd_n_d  = 1'b1;
        end else if (!(bus.dram_waitrequest && !rd_n_q)) begin
          // Not stalled: present the next word if the in-flight window allows.
          rd_n_d = !(outst_d < MAX_OUT);
          addr_d = base_q + 25'(issue_d);
        end
      end
      S_DRAIN: begin
        if (recv_q == LINE_CNT) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      bank_q  <= 1'b0;
      issue_q <= '0;
      recv_q  <= '0;
      outst_q <= '0;
      rd_n_q  <= 1'b1;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      bank_q  <= bank_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      outst_q <= outst_d;
      rd_n_q  <= rd_n_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      wr_q    <= wr_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign overrun_o        = ovr_q;
  assign bus.dram_read_n  = rd_n_q;
  assign bus.dram_address = addr_q;
  assign bus.ocm_we_b     = wr_q.we;
  assign bus.ocm_addr_b   = wr_q.addr;
  assign bus.ocm_datain_b = wr_q.data;

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Bench for fb_line_fetcher: SDRAM model with configurable latency/stalls,
// expected OCM writes queued at request time and checked by a monitor.
module tb_fb_line_fetcher;
  localparam int LW   = 640;
  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst_n, line_req;
  logic [9:0] line_y;
  logic       busy, done, overrun;

  always #5 clk = ~clk;

  fb_line_fetcher_if bus();

  fb_line_fetcher #(.LINE_WORDS(LW), .FB_BASE(25'h0), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .line_req_i(line_req), .line_y_i(line_y),
    .busy_o(busy), .done_o(done), .overrun_o(overrun), .bus(bus)
  );

  typedef struct { int due; logic [24:0] addr; bit stale; } rd_t;
  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;

  rd_t pend[$];
  wr_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, lat = 3;
  bit rand_wait = 0;
  logic [24:0] exp_addr = '0;
  int acc_cnt = 0, addr_bad = 0, stall_bad = 0, stalls = 0, mo = 0, max_mo = 0;
  int wr_cnt = 0, done_cnt = 0;

  function automatic logic [15:0] pix(input int a);
    return 16'(a * 3 + 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  // SDRAM model: acts at #1 after each edge, deciding inputs for the next edge.
  initial begin
    rd_t r;
    bit  acc_pend, val_pend, prev_stall;
    logic [24:0] prev_addr;
    acc_pend = 0; val_pend = 0; prev_stall = 0; prev_addr = '0;
    bus.dram_waitrequest = 1'b0;
    bus.dram_read_valid  = 1'b0;
    bus.data_from_dram   = 16'h0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (rst_n !== 1'b1) begin
        foreach (pend[i]) pend[i].stale = 1'b1;
        mo = 0;
        prev_stall = 0;
      end else begin
        mo = mo + int'(acc_pend) - int'(val_pend);
        if (mo > max_mo) max_mo = mo;
        if (prev_stall && (bus.dram_read_n !== 1'b0 || bus.dram_address !== prev_addr))
          stall_bad++;
      end
      acc_pend = 0;
      val_pend = 0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        r = pend.pop_front();
        bus.dram_read_valid = 1'b1;
        bus.data_from_dram  = pix(int'(r.addr));
        val_pend = !r.stale;
      end else begin
        bus.dram_read_valid = 1'b0;
        bus.data_from_dram  = 16'($urandom);
      end
      bus.dram_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_stall = 0;
      if (rst_n === 1'b1 && bus.dram_read_n === 1'b0) begin
        if (bus.dram_waitrequest) begin
          prev_stall = 1;
          prev_addr  = bus.dram_address;
          stalls++;
        end else begin
          if (bus.dram_address !== exp_addr) addr_bad++;
          exp_addr++;
          acc_cnt++;
          r.due = cyc + 1 + lat;
          r.addr = bus.dram_address;
          r.stale = 1'b0;
          pend.push_back(r);
          acc_pend = 1;
        end
      end
    end
  end

  // Monitor: every OCM write must match the next expected entry.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk); #3;
      if (bus.ocm_we_b === 1'b1) begin
        wr_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ocm_write_unexpected: got addr=%0d data=%0h, expected no write",
                   bus.ocm_addr_b, bus.ocm_datain_b);
        end else begin
          e = sb.pop_front();
          if (bus.ocm_addr_b !== e.a || bus.ocm_datain_b !== e.d) begin
            errors++;
            $display("FAIL ocm_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                     bus.ocm_addr_b, bus.ocm_datain_b, e.a, e.d);
          end
        end
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_read_n"}, bus.dram_read_n, 1);
    chk({tag, "_dram_addr"}, bus.dram_address, 0);
    chk({tag, "_ocm_we"}, bus.ocm_we_b, 0);
    chk({tag, "_ocm_addr"}, bus.ocm_addr_b, 0);
    chk({tag, "_ocm_data"}, bus.ocm_datain_b, 0);
  endtask

  task automatic start_line(input int y);
    wr_t w;
    sb.delete();
    for (int k = 0; k < LW; k++) begin
      w.a = 16'((y % 2) * LW + k);
      w.d = pix(y * LW + k);
      sb.push_back(w);
    end
    exp_addr = 25'(y * LW);
    acc_cnt = 0; addr_bad = 0; stall_bad = 0; stalls = 0; max_mo = 0;
    line_y = 10'(y);
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    chk("busy_after_req", busy, 1);
    chk("read_n_after_req", bus.dram_read_n, 0);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 5000) begin
      step();
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE after %0d cycles, expected DONE", n);
    end
  endtask

  task automatic finish_line(input string tag, input int dones_before);
    chk({tag, "_busy_at_done"}, busy, 0);
    repeat (4) step();
    chk({tag, "_all_words_written"}, sb.size(), 0);
    chk({tag, "_done_once"}, done_cnt - dones_before, 1);
    chk({tag, "_dram_addr_order"}, addr_bad, 0);
    chk({tag, "_accepts"}, acc_cnt, LW);
    chk({tag, "_stall_hold"}, stall_bad, 0);
    chk({tag, "_outstanding_le_max"}, max_mo <= MAXO, 1);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int n, d0, w0;
    rst_n = 1'b0; line_req = 1'b0; line_y = '0;
    repeat (3) step();
    check_reset("reset");
    rst_n = 1'b1;
    step();

    // line 0, no stalls, latency 3
    d0 = done_cnt;
    start_line(0);
    wait_done(n);
    chk("line0_span", n, LW + 5);
    finish_line("line0", d0);

    // line 1 lands in the upper OCM half
    d0 = done_cnt;
    start_line(1);
    wait_done(n);
    chk("line1_span", n, LW + 5);
    finish_line("line1", d0);

    // random waitrequest
    rand_wait = 1;
    d0 = done_cnt;
    start_line(5);
    wait_done(n);
    finish_line("stall", d0);
    chk("stall_seen", stalls > 0, 1);
    rand_wait = 0;

    // long latency: window must fill but never exceed MAX_OUTSTANDING
    lat = 10;
    d0 = done_cnt;
    start_line(2);
    wait_done(n);
    finish_line("lat10", d0);
    chk("lat10_window_full", max_mo, MAXO);
    lat = 3;

    // second request mid-fetch
    d0 = done_cnt;
    start_line(3);
    repeat (100) step();
    line_y = 10'd7;
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    chk("overrun_set", overrun, 1);
    wait_done(n);
    finish_line("overrun", d0);
    repeat (5) step();
    chk("overrun_sticky", overrun, 1);

    // reset mid-fetch, stale returns must be dropped
    start_line(4);
    w0 = wr_cnt;
    n = 0;
    while (wr_cnt - w0 < 300 && n < 2000) begin
      step();
      n++;
    end
    chk("reached_word_300", wr_cnt - w0 >= 300, 1);
    rst_n = 1'b0;
    step();
    check_reset("midreset");
    rst_n = 1'b1;
    sb.delete();
    w0 = wr_cnt;
    n = 0;
    while (pend.size() > 0 && n < 100) begin
      step();
      n++;
    end
    repeat (5) step();
    chk("no_writes_after_reset", wr_cnt - w0, 0);
    chk("busy_after_reset", busy, 0);

    d0 = done_cnt;
    start_line(6);
    wait_done(n);
    chk("post_reset_span", n, LW + 5);
    finish_line("postreset", d0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
